rvfi_pc_gen: RTL and testbench

RVFI_PC_GEN -- requirements
Module: rvfi_pc_gen

---
 rtl/rvfi_pc_gen_pkg.sv | 34 +++
 rtl/rvfi_pc_gen_lfsr.sv | 33 +++
 rtl/rvfi_pc_gen.sv | 169 ++++++++++++++++
 tb/tb_rvfi_pc_gen.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_pc_gen_pkg.sv
// Shared widths, state encoding and constants for the RVFI PC stream generator.
// XLEN/NRET come from the riscv-formal macros, with local fallbacks.
`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif
`ifndef RISCV_FORMAL_NRET
`define RISCV_FORMAL_NRET 2
`endif

package rvfi_gen_pkg;
    localparam int XLEN = `RISCV_FORMAL_XLEN;
    localparam int NRET = `RISCV_FORMAL_NRET;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } gen_state_e;

    localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
    localparam int          PC_INC       = 4;
    localparam logic [1:0]  INSN_LO      = 2'b11;
    localparam int          FAULT_PC_XOR = 4;

    // Right-shifting Galois step: feedback taps applied when the bit shifted out is set.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        logic [31:0] s;
        s = v >> 1;
        if (v[0]) begin
            s = s ^ LFSR_POLY;
        end
        return s;
    endfunction
endpackage

// File: rtl/rvfi_pc_gen_lfsr.sv
// 32-bit Galois LFSR that can be reloaded with its seed synchronously,
// so a new run can restart the sequence without a reset.
module rvfi_lfsr
    import rvfi_gen_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] seed,
    input  logic        load,
    input  logic        advance,
    output logic [31:0] value
);
    logic [31:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = seed;
        end else if (advance) begin
            value_d = lfsr_step(value_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_q <= seed;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
endmodule

// File: rtl/rvfi_pc_gen.sv
// RVFI retirement stream generator: a pseudo-random but self-consistent PC/order chain
// over NRET channels. Defining RVFI_PC_GEN_FAULT_EN adds a one-shot pc_rdata corruption input.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | retiring up to NRET instructions per non-stalled cycle
//   DONE  | MAX_RET retired, done asserted, waiting for start
module rvfi_pc_gen
    import rvfi_gen_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     MAX_RET  = 32'd1024,
    parameter logic [31:0]     SEED     = 32'h1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stall,
`ifdef RVFI_PC_GEN_FAULT_EN
    input  logic                 fault_inject,
`endif
    output logic [NRET-1:0]      rvfi_valid,
    output logic [NRET*64-1:0]   rvfi_order,
    output logic [NRET*32-1:0]   rvfi_insn,
    output logic [NRET*XLEN-1:0] rvfi_pc_rdata,
    output logic [NRET*XLEN-1:0] rvfi_pc_wdata,
    output logic                 done
);
    gen_state_e state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [63:0] order_q, order_d;
    logic [31:0] remaining_q, remaining_d;
    logic done_q, done_d;

    logic [NRET-1:0]      valid_q, valid_d;
    logic [NRET*64-1:0]   ord_out_q, ord_out_d;
    logic [NRET*32-1:0]   insn_q, insn_d;
    logic [NRET*XLEN-1:0] pc_rdata_q, pc_rdata_d;
    logic [NRET*XLEN-1:0] pc_wdata_q, pc_wdata_d;

    logic [31:0]     lfsr_val;
    logic            lfsr_load;
    logic            lfsr_adv;
    logic            retire;
    logic [31:0]     k;
    logic [XLEN-1:0] pc_walk;
    logic [XLEN-1:0] pc_next;

`ifdef RVFI_PC_GEN_FAULT_EN
    logic fault_armed_q, fault_armed_d;
    logic fault_used;
`endif

    rvfi_lfsr u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .seed    (SEED),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .value   (lfsr_val)
    );

    always_comb begin
        retire    = (state_q == RUN) && !stall;
        lfsr_load = (state_q != RUN) && start;
        lfsr_adv  = retire;

        k = 32'(lfsr_val[7:0]) % 32'(NRET + 1);
        if (k > remaining_q) begin
            k = remaining_q;
        end

        state_d     = state_q;
        pc_d        = pc_q;
        order_d     = order_q;
        remaining_d = remaining_q;
        done_d      = (state_q == DONE) && !start;

        valid_d    = '0;
        ord_out_d  = '0;
        insn_d     = '0;
        pc_rdata_d = '0;
        pc_wdata_d = '0;
        pc_walk    = pc_q;
        pc_next    = pc_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    pc_d        = RESET_PC;
                    order_d     = '0;
                    remaining_d = MAX_RET;
                end
            end
            RUN: begin
                if (!stall) begin
                    // Channels fill from 0; each one chains off the previous channel's next PC.
                    for (int i = 0; i < NRET; i++) begin
                        if (32'(i) < k) begin
                            pc_next = lfsr_val[8+i] ? XLEN'({lfsr_val[31:2], 2'b00})
                                                    : pc_walk + XLEN'(PC_INC);
                            valid_d[i]                   = 1'b1;
                            ord_out_d[i*64 +: 64]        = order_q + 64'(i);
                            insn_d[i*32 +: 32]           = {lfsr_val[31:2], INSN_LO};
                            pc_rdata_d[i*XLEN +: XLEN]   = pc_walk;
                            pc_wdata_d[i*XLEN +: XLEN]   = pc_next;
                            pc_walk                      = pc_next;
                        end
                    end
                    pc_d        = pc_walk;
                    order_d     = order_q + 64'(k);
                    remaining_d = remaining_q - k;
                    if (remaining_q == k) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef RVFI_PC_GEN_FAULT_EN
        // Corrupts only the reported pc_rdata of the next retirement; pc_d is left intact.
        fault_used = fault_armed_q && retire && (k != 32'd0);
        if (fault_used) begin
            pc_rdata_d[XLEN-1:0] = pc_rdata_d[XLEN-1:0] ^ XLEN'(FAULT_PC_XOR);
        end
        fault_armed_d = (fault_armed_q && !fault_used) || fault_inject;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            order_q     <= '0;
            remaining_q <= MAX_RET;
            done_q      <= 1'b0;
            valid_q     <= '0;
            ord_out_q   <= '0;
            insn_q      <= '0;
            pc_rdata_q  <= '0;
            pc_wdata_q  <= '0;
`ifdef RVFI_PC_GEN_FAULT_EN
            fault_armed_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            order_q     <= order_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            ord_out_q   <= ord_out_d;
            insn_q      <= insn_d;
            pc_rdata_q  <= pc_rdata_d;
            pc_wdata_q  <= pc_wdata_d;
`ifdef RVFI_PC_GEN_FAULT_EN
            fault_armed_q <= fault_armed_d;
`endif
        end
    end

    assign rvfi_valid    = valid_q;
    assign rvfi_order    = ord_out_q;
    assign rvfi_insn     = insn_q;
    assign rvfi_pc_rdata = pc_rdata_q;
    assign rvfi_pc_wdata = pc_wdata_q;
    assign done          = done_q;
endmodule

// File: tb/tb_rvfi_pc_gen.sv
// Bench for rvfi_pc_gen: a short-run and a long-run instance share stimulus and are
// compared every cycle against a behavioural retirement-stream model.
`timescale 1ns/1ps
module tb_rvfi_pc_gen;
    localparam int XLEN = rvfi_gen_pkg::XLEN;
    localparam int NRET = rvfi_gen_pkg::NRET;

    localparam logic [XLEN-1:0] PC_A   = XLEN'(32'h100);
    localparam logic [XLEN-1:0] PC_B   = {XLEN{1'b1}} << 2;
    localparam logic [31:0]     MAX_A  = 32'd3;
    localparam logic [31:0]     MAX_B  = 32'd40;
    localparam logic [31:0]     SEED_A = 32'h1;
    localparam logic [31:0]     SEED_B = 32'h1234_5601;

    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;

`ifdef RVFI_PC_GEN_FAULT_EN
    localparam int EXP_FIRES = 1;
`else
    localparam int EXP_FIRES = 0;
`endif

    logic clock, reset, start, stall;
`ifdef RVFI_PC_GEN_FAULT_EN
    logic fault_inject;
`endif

    logic [NRET-1:0]      a_valid, b_valid;
    logic [NRET*64-1:0]   a_order, b_order;
    logic [NRET*32-1:0]   a_insn, b_insn;
    logic [NRET*XLEN-1:0] a_rd, a_wd, b_rd, b_wd;
    logic                 a_done, b_done;

    rvfi_pc_gen #(.RESET_PC(PC_A), .MAX_RET(MAX_A), .SEED(SEED_A)) u_a (
        .clock(clock), .reset(reset), .start(start), .stall(stall),
`ifdef RVFI_PC_GEN_FAULT_EN
        .fault_inject(fault_inject),
`endif
        .rvfi_valid(a_valid), .rvfi_order(a_order), .rvfi_insn(a_insn),
        .rvfi_pc_rdata(a_rd), .rvfi_pc_wdata(a_wd), .done(a_done)
    );

    rvfi_pc_gen #(.RESET_PC(PC_B), .MAX_RET(MAX_B), .SEED(SEED_B)) u_b (
        .clock(clock), .reset(reset), .start(start), .stall(stall),
`ifdef RVFI_PC_GEN_FAULT_EN
        .fault_inject(fault_inject),
`endif
        .rvfi_valid(b_valid), .rvfi_order(b_order), .rvfi_insn(b_insn),
        .rvfi_pc_rdata(b_rd), .rvfi_pc_wdata(b_wd), .done(b_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model state, one slot per instance
    logic [XLEN-1:0]      cfg_pc   [2];
    longint               cfg_max  [2];
    logic [31:0]          cfg_seed [2];
    int                   m_phase  [2];
    logic [XLEN-1:0]      m_pc     [2];
    longint unsigned      m_ord    [2];
    longint               m_rem    [2];
    logic [31:0]          m_lfsr   [2];
    logic                 m_done   [2];
    logic                 m_armed  [2];
    int                   m_retired[2];
    logic [NRET-1:0]      e_valid  [2];
    logic [NRET*64-1:0]   e_order  [2];
    logic [NRET*32-1:0]   e_insn   [2];
    logic [NRET*XLEN-1:0] e_rd     [2];
    logic [NRET*XLEN-1:0] e_wd     [2];

    int n_checks = 0;
    int n_fail   = 0;

    int              a_total;
    logic [XLEN-1:0] a_first_rd, b_first_rd, b_first_wd;
    int              pc_chk_fires = 0;
    logic [XLEN-1:0] pc_chk_prev;

    logic [NRET-1:0]      q_v    [$];
    logic [XLEN-1:0]      q_rd0  [$];
    logic [31:0]          q_insn0[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        logic [31:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 32'h8020_0003;
        return s;
    endfunction

    task automatic model_reset(input int d);
        m_phase[d]   = P_IDLE;
        m_pc[d]      = cfg_pc[d];
        m_ord[d]     = 0;
        m_rem[d]     = cfg_max[d];
        m_lfsr[d]    = cfg_seed[d];
        m_done[d]    = 1'b0;
        m_armed[d]   = 1'b0;
        m_retired[d] = 0;
        e_valid[d]   = '0;
        e_order[d]   = '0;
        e_insn[d]    = '0;
        e_rd[d]      = '0;
        e_wd[d]      = '0;
    endtask

    task automatic model_step(input int d);
        int k;
        logic [XLEN-1:0] rd, wd, tgt;
        logic used;
        e_valid[d] = '0;
        e_order[d] = '0;
        e_insn[d]  = '0;
        e_rd[d]    = '0;
        e_wd[d]    = '0;
        used = 1'b0;
        if (m_phase[d] != P_RUN) begin
            if (start) begin
                m_phase[d]   = P_RUN;
                m_pc[d]      = cfg_pc[d];
                m_ord[d]     = 0;
                m_rem[d]     = cfg_max[d];
                m_lfsr[d]    = cfg_seed[d];
                m_done[d]    = 1'b0;
                m_retired[d] = 0;
            end else begin
                m_done[d] = (m_phase[d] == P_DONE);
            end
        end else if (!stall) begin
            k = int'(m_lfsr[d] & 32'hFF) % (NRET + 1);
            if (longint'(k) > m_rem[d]) k = int'(m_rem[d]);
            tgt = XLEN'(m_lfsr[d] & 32'hFFFF_FFFC);
            for (int i = 0; i < k; i++) begin
                rd = m_pc[d];
                wd = m_lfsr[d][8+i] ? tgt : rd + XLEN'(4);
                e_valid[d][i]              = 1'b1;
                e_order[d][i*64 +: 64]     = m_ord[d] + 64'(i);
                e_insn[d][i*32 +: 32]      = {m_lfsr[d][31:2], 2'b11};
                e_rd[d][i*XLEN +: XLEN]    = (i == 0 && m_armed[d]) ? (rd ^ XLEN'(4)) : rd;
                e_wd[d][i*XLEN +: XLEN]    = wd;
                if (i == 0 && m_armed[d]) used = 1'b1;
                m_pc[d] = wd;
            end
            m_ord[d]     += longint'(k);
            m_rem[d]     -= longint'(k);
            m_retired[d] += k;
            m_lfsr[d]     = lfsr_next(m_lfsr[d]);
            if (m_rem[d] == 0) m_phase[d] = P_DONE;
        end
        m_armed[d] = m_armed[d] && !used;
`ifdef RVFI_PC_GEN_FAULT_EN
        m_armed[d] = m_armed[d] || fault_inject;
`endif
    endtask

    task automatic compare_dut(input int d);
        logic [NRET-1:0]      v;
        logic [NRET*64-1:0]   o;
        logic [NRET*32-1:0]   n;
        logic [NRET*XLEN-1:0] r, w;
        logic                 dn;
        if (d == 0) begin
            v = a_valid; o = a_order; n = a_insn; r = a_rd; w = a_wd; dn = a_done;
        end else begin
            v = b_valid; o = b_order; n = b_insn; r = b_rd; w = b_wd; dn = b_done;
        end
        chk($sformatf("valid[%0d]", d), 64'(v), 64'(e_valid[d]));
        chk($sformatf("done[%0d]", d), 64'(dn), 64'(m_done[d]));
        for (int i = 0; i < NRET; i++) begin
            chk($sformatf("order[%0d].ch%0d", d, i), o[i*64 +: 64], e_order[d][i*64 +: 64]);
            chk($sformatf("insn[%0d].ch%0d", d, i), 64'(n[i*32 +: 32]), 64'(e_insn[d][i*32 +: 32]));
            chk($sformatf("pc_rdata[%0d].ch%0d", d, i), 64'(r[i*XLEN +: XLEN]), 64'(e_rd[d][i*XLEN +: XLEN]));
            chk($sformatf("pc_wdata[%0d].ch%0d", d, i), 64'(w[i*XLEN +: XLEN]), 64'(e_wd[d][i*XLEN +: XLEN]));
        end
    endtask

    // Observes the DUT streams: retirement counts, first retirements, PC-consistency checker on u_b.
    task automatic observe();
        for (int i = 0; i < NRET; i++) begin
            if (a_valid[i]) begin
                a_total++;
                if (a_order[i*64 +: 64] == 64'd0) a_first_rd = a_rd[i*XLEN +: XLEN];
            end
            if (b_valid[i]) begin
                if (b_order[i*64 +: 64] == 64'd0) begin
                    b_first_rd  = b_rd[i*XLEN +: XLEN];
                    b_first_wd  = b_wd[i*XLEN +: XLEN];
                    pc_chk_prev = PC_B;
                end
                if (b_rd[i*XLEN +: XLEN] != pc_chk_prev) pc_chk_fires++;
                pc_chk_prev = b_wd[i*XLEN +: XLEN];
            end
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        if (reset) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0);
            model_step(1);
        end
        @(negedge clock);
        compare_dut(0);
        compare_dut(1);
        observe();
    endtask

    task automatic wait_done_b(input int bound);
        int n;
        n = 0;
        while (!b_done && n < bound) begin
            cycle();
            n++;
        end
        chk("b_done_reached", 64'(b_done), 64'd1);
    endtask

    task automatic reset_and_start();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        int n;
        cfg_pc[0] = PC_A; cfg_max[0] = longint'(MAX_A); cfg_seed[0] = SEED_A;
        cfg_pc[1] = PC_B; cfg_max[1] = longint'(MAX_B); cfg_seed[1] = SEED_B;
        model_reset(0);
        model_reset(1);
        reset = 1'b1; start = 1'b0; stall = 1'b0;
`ifdef RVFI_PC_GEN_FAULT_EN
        fault_inject = 1'b0;
`endif
        pc_chk_prev = PC_B;
        a_total = 0; a_first_rd = '0; b_first_rd = '0; b_first_wd = '1;

        repeat (3) cycle();
        reset = 1'b0;
        repeat (4) begin
            stall = 1'($urandom_range(0, 1));
            cycle();
        end
        stall = 1'b0;

        // Run with a held 5-cycle stall mid-run
        a_total = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (4) cycle();
        stall = 1'b1;
        repeat (5) begin
            cycle();
            chk("stall_valid_a", 64'(a_valid), 64'd0);
            chk("stall_valid_b", 64'(b_valid), 64'd0);
        end
        stall = 1'b0;
        wait_done_b(300);
        repeat (3) cycle();
        chk("a_total_valids", 64'(a_total), 64'd3);
        chk("a_first_pc_rdata", 64'(a_first_rd), 64'(PC_A));
        chk("b_first_pc_rdata", 64'(b_first_rd), 64'(PC_B));
        chk("b_wrap_pc_wdata", 64'(b_first_wd), 64'd0);
        chk("a_done_held", 64'(a_done), 64'd1);

        // Reset in the middle of a run after at least 10 retirements
        reset_and_start();
        n = 0;
        while (m_retired[1] < 10 && n < 200) begin
            stall = ($urandom_range(0, 4) == 0);
            cycle();
            n++;
        end
        chk("b_reached_10", 64'(m_retired[1] >= 10), 64'd1);
        stall = 1'b0;
        reset = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        compare_dut(0);
        compare_dut(1);
        chk("reset_same_cycle_valid_b", 64'(b_valid), 64'd0);
        repeat (2) cycle();
        reset = 1'b0;
        cycle();
        chk("idle_after_reset_done", 64'(b_done), 64'd0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        n = 0;
        while (!b_valid[0] && n < 50) begin
            cycle();
            n++;
        end
        chk("b_restart_order", b_order[63:0], 64'd0);
        chk("b_restart_pc_rdata", 64'(b_rd[XLEN-1:0]), 64'(PC_B));
        wait_done_b(300);

        // Same seed gives the same stream: record run one, replay against run two
        reset_and_start();
        repeat (30) begin
            cycle();
            q_v.push_back(e_valid[1]);
            q_rd0.push_back(e_rd[1][XLEN-1:0]);
            q_insn0.push_back(e_insn[1][31:0]);
        end
        reset_and_start();
        for (int j = 0; j < 30; j++) begin
            cycle();
            chk("rerun_valid", 64'(b_valid), 64'(q_v[j]));
            chk("rerun_pc_rdata0", 64'(b_rd[XLEN-1:0]), 64'(q_rd0[j]));
            chk("rerun_insn0", 64'(b_insn[31:0]), 64'(q_insn0[j]));
        end
        wait_done_b(300);

`ifdef RVFI_PC_GEN_FAULT_EN
        reset_and_start();
        n = 0;
        while (m_retired[1] < 4 && n < 100) begin
            cycle();
            n++;
        end
        fault_inject = 1'b1;
        cycle();
        fault_inject = 1'b0;
        wait_done_b(300);
`endif

        // Random start/stall traffic, including start and stall outside their states
        repeat (150) begin
            start = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 3) == 0);
            cycle();
        end
        start = 1'b0;
        stall = 1'b0;
        repeat (2) cycle();

        chk("pc_checker_fires", 64'(pc_chk_fires), 64'(EXP_FIRES));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
